// File: rtl/cq_packet_steer.sv
// cq_packet_steer: latches the CQ routing decision at SOP and steers each whole packet to the
// DSP or USP output, or drops it while capturing its header. Build macro: CQ_STEER_STATS_EN.
module cq_packet_steer #(
  parameter int DSP_IF_WIDTH       = 512,
  parameter int DSP_CQ_TUSER_WIDTH = 231,
  parameter int DSP_TKEEP_WIDTH    = 16,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          user_clk,
  input  logic                          user_reset_n,
  input  logic [DSP_IF_WIDTH-1:0]       s_axis_cq_tdata,
  input  logic [DSP_TKEEP_WIDTH-1:0]    s_axis_cq_tkeep,
  input  logic                          s_axis_cq_tlast,
  input  logic [DSP_CQ_TUSER_WIDTH-1:0] s_axis_cq_tuser,
  input  logic                          s_axis_cq_tvalid,
  output logic                          s_axis_cq_tready,
  input  logic [1:0]                    select,
  input  logic                          unsupported_req,
  output logic [DSP_IF_WIDTH-1:0]       m_axis_dsp_tdata,
  output logic [DSP_TKEEP_WIDTH-1:0]    m_axis_dsp_tkeep,
  output logic                          m_axis_dsp_tlast,
  output logic [DSP_CQ_TUSER_WIDTH-1:0] m_axis_dsp_tuser,
  output logic                          m_axis_dsp_tvalid,
  input  logic                          m_axis_dsp_tready,
  output logic [DSP_IF_WIDTH-1:0]       m_axis_usp_tdata,
  output logic [DSP_TKEEP_WIDTH-1:0]    m_axis_usp_tkeep,
  output logic                          m_axis_usp_tlast,
  output logic [DSP_CQ_TUSER_WIDTH-1:0] m_axis_usp_tuser,
  output logic                          m_axis_usp_tvalid,
  input  logic                          m_axis_usp_tready,
  output logic [127:0]                  ur_hdr,
  output logic                          ur_valid,
  input  logic                          ur_ack,
  output logic [CNT_WIDTH-1:0]          cnt_dsp,
  output logic [CNT_WIDTH-1:0]          cnt_usp,
  output logic [CNT_WIDTH-1:0]          cnt_drop
);

  typedef enum logic [1:0] {IDLE, FWD_DSP, FWD_USP, DROP} state_t;
  typedef enum logic [1:0] {DEST_DSP, DEST_USP, DEST_DROP} dest_t;

  state_t       state_reg;
  dest_t        dest;
  logic         sop;
  logic         accept;
  logic         ur_load;
  logic         ur_valid_reg;
  logic [127:0] ur_hdr_reg;

  // Index 0 is the DSP output stage, index 1 the USP output stage.
  logic [1:0]                         stage_load;
  logic [1:0]                         stage_ready;
  logic [1:0]                         stage_valid;
  logic [1:0]                         stage_last;
  logic [1:0][DSP_IF_WIDTH-1:0]       stage_data;
  logic [1:0][DSP_TKEEP_WIDTH-1:0]    stage_keep;
  logic [1:0][DSP_CQ_TUSER_WIDTH-1:0] stage_user;

  assign stage_ready = {m_axis_usp_tready, m_axis_dsp_tready};
  assign sop         = (state_reg == IDLE);

  always_comb begin
    dest = DEST_DROP;
    case (state_reg)
      IDLE: begin
        if (unsupported_req)     dest = DEST_DROP;
        else if (select == 2'd0) dest = DEST_DSP;
        else if (select == 2'd1) dest = DEST_USP;
        else                     dest = DEST_DROP;
      end
      FWD_DSP: dest = DEST_DSP;
      FWD_USP: dest = DEST_USP;
      default: dest = DEST_DROP;
    endcase
  end

  // A dropped SOP only waits for the UR header slot; dropped continuation beats are sunk.
  always_comb begin
    s_axis_cq_tready = 1'b1;
    case (dest)
      DEST_DSP: s_axis_cq_tready = !stage_valid[0] || stage_ready[0];
      DEST_USP: s_axis_cq_tready = !stage_valid[1] || stage_ready[1];
      default:  s_axis_cq_tready = !sop || !ur_valid_reg || ur_ack;
    endcase
  end

  assign accept        = s_axis_cq_tvalid && s_axis_cq_tready;
  assign stage_load[0] = accept && (dest == DEST_DSP);
  assign stage_load[1] = accept && (dest == DEST_USP);
  assign ur_load       = accept && sop && (dest == DEST_DROP);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stage
      logic                          valid_reg;
      logic                          last_reg;
      logic [DSP_IF_WIDTH-1:0]       data_reg;
      logic [DSP_TKEEP_WIDTH-1:0]    keep_reg;
      logic [DSP_CQ_TUSER_WIDTH-1:0] user_reg;

      always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          data_reg  <= '0;
          keep_reg  <= '0;
          user_reg  <= '0;
        end else if (stage_load[gi]) begin
          valid_reg <= 1'b1;
          last_reg  <= s_axis_cq_tlast;
          data_reg  <= s_axis_cq_tdata;
          keep_reg  <= s_axis_cq_tkeep;
          user_reg  <= s_axis_cq_tuser;
        end else if (stage_ready[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_last[gi]  = last_reg;
      assign stage_data[gi]  = data_reg;
      assign stage_keep[gi]  = keep_reg;
      assign stage_user[gi]  = user_reg;
    end
  endgenerate

  assign m_axis_dsp_tvalid = stage_valid[0];
  assign m_axis_dsp_tlast  = stage_last[0];
  assign m_axis_dsp_tdata  = stage_data[0];
  assign m_axis_dsp_tkeep  = stage_keep[0];
  assign m_axis_dsp_tuser  = stage_user[0];
  assign m_axis_usp_tvalid = stage_valid[1];
  assign m_axis_usp_tlast  = stage_last[1];
  assign m_axis_usp_tdata  = stage_data[1];
  assign m_axis_usp_tkeep  = stage_keep[1];
  assign m_axis_usp_tuser  = stage_user[1];

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_reg <= IDLE;
    end else if (accept) begin
      if (s_axis_cq_tlast) begin
        state_reg <= IDLE;
      end else if (sop) begin
        case (dest)
          DEST_DSP: state_reg <= FWD_DSP;
          DEST_USP: state_reg <= FWD_USP;
          default:  state_reg <= DROP;
        endcase
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      ur_valid_reg <= 1'b0;
      ur_hdr_reg   <= '0;
    end else if (ur_load) begin
      ur_valid_reg <= 1'b1;
      ur_hdr_reg   <= s_axis_cq_tdata[127:0];
    end else if (ur_ack) begin
      ur_valid_reg <= 1'b0;
    end
  end

  assign ur_valid = ur_valid_reg;
  assign ur_hdr   = ur_hdr_reg;

`ifdef CQ_STEER_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_dsp_reg;
  logic [CNT_WIDTH-1:0] cnt_usp_reg;
  logic [CNT_WIDTH-1:0] cnt_drop_reg;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      cnt_dsp_reg  <= '0;
      cnt_usp_reg  <= '0;
      cnt_drop_reg <= '0;
    end else if (accept && sop) begin
      case (dest)
        DEST_DSP: if (cnt_dsp_reg != '1) cnt_dsp_reg <= cnt_dsp_reg + CNT_ONE;
        DEST_USP: if (cnt_usp_reg != '1) cnt_usp_reg <= cnt_usp_reg + CNT_ONE;
        default:  if (cnt_drop_reg != '1) cnt_drop_reg <= cnt_drop_reg + CNT_ONE;
      endcase
    end
  end

  assign cnt_dsp  = cnt_dsp_reg;
  assign cnt_usp  = cnt_usp_reg;
  assign cnt_drop = cnt_drop_reg;
`else
  assign cnt_dsp  = '0;
  assign cnt_usp  = '0;
  assign cnt_drop = '0;
`endif

endmodule

// File: tb/tb_cq_packet_steer.sv
// Bench for cq_packet_steer: directed scenarios plus random packets checked against a
// packet-level queue model of the three destinations.
module tb_cq_packet_steer;
  localparam int DW = 512;
  localparam int UW = 231;
  localparam int KW = 16;
  localparam int CW = 4;
`ifdef CQ_STEER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          user_clk = 1'b0;
  logic          user_reset_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [1:0]    s_select = 2'd3;
  logic          s_ur = 1'b0;
  logic [DW-1:0] dsp_tdata, usp_tdata;
  logic [KW-1:0] dsp_tkeep, usp_tkeep;
  logic          dsp_tlast, usp_tlast, dsp_tvalid, usp_tvalid;
  logic [UW-1:0] dsp_tuser, usp_tuser;
  logic          dsp_tready = 1'b1;
  logic          usp_tready = 1'b1;
  logic [127:0]  ur_hdr;
  logic          ur_valid;
  logic          ur_ack = 1'b0;
  logic [CW-1:0] cnt_dsp, cnt_usp, cnt_drop;

  always #5 user_clk = ~user_clk;

  cq_packet_steer #(
    .DSP_IF_WIDTH(DW), .DSP_CQ_TUSER_WIDTH(UW), .DSP_TKEEP_WIDTH(KW), .CNT_WIDTH(CW)
  ) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .s_axis_cq_tdata(s_tdata), .s_axis_cq_tkeep(s_tkeep), .s_axis_cq_tlast(s_tlast),
    .s_axis_cq_tuser(s_tuser), .s_axis_cq_tvalid(s_tvalid), .s_axis_cq_tready(s_tready),
    .select(s_select), .unsupported_req(s_ur),
    .m_axis_dsp_tdata(dsp_tdata), .m_axis_dsp_tkeep(dsp_tkeep), .m_axis_dsp_tlast(dsp_tlast),
    .m_axis_dsp_tuser(dsp_tuser), .m_axis_dsp_tvalid(dsp_tvalid), .m_axis_dsp_tready(dsp_tready),
    .m_axis_usp_tdata(usp_tdata), .m_axis_usp_tkeep(usp_tkeep), .m_axis_usp_tlast(usp_tlast),
    .m_axis_usp_tuser(usp_tuser), .m_axis_usp_tvalid(usp_tvalid), .m_axis_usp_tready(usp_tready),
    .ur_hdr(ur_hdr), .ur_valid(ur_valid), .ur_ack(ur_ack),
    .cnt_dsp(cnt_dsp), .cnt_usp(cnt_usp), .cnt_drop(cnt_drop)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  // Reference model: beats in flight per output, pending UR headers, packet counts.
  beat_t        q_dsp[$];
  beat_t        q_usp[$];
  logic [127:0] q_ur[$];
  int n_dsp, n_usp, n_drop;
  bit in_pkt;
  int cur_dest;

  int total = 0;
  int bad = 0;
  bit last_acc, last_tready, last_dsp_v, last_usp_v;
  int obs_dsp = 0;
  int obs_usp = 0;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [255:0] u;
    for (int i = 0; i < 8; i++) u[i*32 +: 32] = $urandom;
    return u[UW-1:0];
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int n);
    int lim;
    lim = (1 << CW) - 1;
    if (!STATS) return '0;
    return CW'((n > lim) ? lim : n);
  endfunction

  task automatic set_beat(input bit v, input logic [1:0] sel, input bit ur, input bit last);
    s_tvalid = v;
    s_tdata  = rand_data();
    s_tkeep  = KW'($urandom);
    s_tuser  = rand_user();
    s_tlast  = last;
    s_select = sel;
    s_ur     = ur;
  endtask

  task automatic idle_in();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_select = 2'd3;
    s_ur     = 1'b0;
  endtask

  task automatic model_reset();
    q_dsp.delete();
    q_usp.delete();
    q_ur.delete();
    n_dsp = 0;
    n_usp = 0;
    n_drop = 0;
    in_pkt = 1'b0;
    cur_dest = 0;
  endtask

  // One clock: entered just after a falling edge with inputs applied; checks the DUT
  // against the model, advances the model for the coming rising edge, returns at the next falling edge.
  task automatic tick();
    int    dest;
    bit    sop;
    bit    exp_rdy;
    beat_t b;
    #1;
    sop = !in_pkt;
    if (sop) dest = s_ur ? 2 : (s_select == 2'd0 ? 0 : (s_select == 2'd1 ? 1 : 2));
    else     dest = cur_dest;
    if (dest == 0)      exp_rdy = (q_dsp.size() == 0) || dsp_tready;
    else if (dest == 1) exp_rdy = (q_usp.size() == 0) || usp_tready;
    else                exp_rdy = sop ? ((q_ur.size() == 0) || ur_ack) : 1'b1;

    last_tready = s_tready;
    last_dsp_v  = dsp_tvalid;
    last_usp_v  = usp_tvalid;
    if (dsp_tvalid === 1'b1 && dsp_tready) obs_dsp++;
    if (usp_tvalid === 1'b1 && usp_tready) obs_usp++;

    total++;
    if (s_tready !== exp_rdy) begin
      bad++;
      $display("FAIL s_tready: got %b want %b (dest=%0d sop=%0b)", s_tready, exp_rdy, dest, sop);
    end
    total++;
    if (dsp_tvalid !== (q_dsp.size() != 0)) begin
      bad++;
      $display("FAIL dsp_tvalid: got %b want %b", dsp_tvalid, q_dsp.size() != 0);
    end else if (q_dsp.size() != 0 && (dsp_tdata !== q_dsp[0].data || dsp_tkeep !== q_dsp[0].keep ||
                 dsp_tlast !== q_dsp[0].last || dsp_tuser !== q_dsp[0].user)) begin
      bad++;
      $display("FAIL dsp_beat: got data=%h last=%b want data=%h last=%b",
               dsp_tdata[63:0], dsp_tlast, q_dsp[0].data[63:0], q_dsp[0].last);
    end
    total++;
    if (usp_tvalid !== (q_usp.size() != 0)) begin
      bad++;
      $display("FAIL usp_tvalid: got %b want %b", usp_tvalid, q_usp.size() != 0);
    end else if (q_usp.size() != 0 && (usp_tdata !== q_usp[0].data || usp_tkeep !== q_usp[0].keep ||
                 usp_tlast !== q_usp[0].last || usp_tuser !== q_usp[0].user)) begin
      bad++;
      $display("FAIL usp_beat: got data=%h last=%b want data=%h last=%b",
               usp_tdata[63:0], usp_tlast, q_usp[0].data[63:0], q_usp[0].last);
    end
    total++;
    if (ur_valid !== (q_ur.size() != 0)) begin
      bad++;
      $display("FAIL ur_valid: got %b want %b", ur_valid, q_ur.size() != 0);
    end else if (q_ur.size() != 0 && ur_hdr !== q_ur[0]) begin
      bad++;
      $display("FAIL ur_hdr: got %h want %h", ur_hdr, q_ur[0]);
    end
    total++;
    if ({cnt_dsp, cnt_usp, cnt_drop} !== {exp_cnt(n_dsp), exp_cnt(n_usp), exp_cnt(n_drop)}) begin
      bad++;
      $display("FAIL counters: got %0d/%0d/%0d want %0d/%0d/%0d", cnt_dsp, cnt_usp, cnt_drop,
               exp_cnt(n_dsp), exp_cnt(n_usp), exp_cnt(n_drop));
    end

    if (q_dsp.size() != 0 && dsp_tready) void'(q_dsp.pop_front());
    if (q_usp.size() != 0 && usp_tready) void'(q_usp.pop_front());
    if (q_ur.size() != 0 && ur_ack) void'(q_ur.pop_front());
    last_acc = s_tvalid && exp_rdy;
    if (last_acc) begin
      b.data = s_tdata;
      b.keep = s_tkeep;
      b.last = s_tlast;
      b.user = s_tuser;
      if (dest == 0) begin
        q_dsp.push_back(b);
        if (sop) n_dsp++;
      end else if (dest == 1) begin
        q_usp.push_back(b);
        if (sop) n_usp++;
      end else if (sop) begin
        q_ur.push_back(s_tdata[127:0]);
        n_drop++;
      end
      if (s_tlast) in_pkt = 1'b0;
      else if (sop) begin
        in_pkt = 1'b1;
        cur_dest = dest;
      end
    end
    @(posedge user_clk);
    @(negedge user_clk);
  endtask

  task automatic send_until_acc(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    total++;
    if (!last_acc) begin
      bad++;
      $display("FAIL %s_timeout: got no accept in %0d cycles want accept", name, n);
    end
  endtask

  task automatic test_reset();
    model_reset();
    user_reset_n = 1'b0;
    idle_in();
    repeat (3) @(negedge user_clk);
    total++;
    if ({dsp_tvalid, usp_tvalid, ur_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_valid: got %b want 000", {dsp_tvalid, usp_tvalid, ur_valid});
    end
    total++;
    if ({dsp_tdata, dsp_tkeep, dsp_tlast, dsp_tuser, usp_tdata, usp_tkeep, usp_tlast, usp_tuser,
         ur_hdr, cnt_dsp, cnt_usp, cnt_drop} !== '0) begin
      bad++;
      $display("FAIL reset_data: got nonzero (dsp=%h usp=%h hdr=%h) want 0",
               dsp_tdata[63:0], usp_tdata[63:0], ur_hdr);
    end
    user_reset_n = 1'b1;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL reset_tready: got %b want 1", s_tready);
    end
    $display("test_reset: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_dsp_multibeat();
    int d0, u0;
    dsp_tready = 1'b1;
    usp_tready = 1'b1;
    ur_ack = 1'b0;
    d0 = obs_dsp;
    u0 = obs_usp;
    set_beat(1'b1, 2'd0, 1'b0, 1'b0); tick();
    set_beat(1'b1, 2'd2, 1'b0, 1'b0); tick();
    set_beat(1'b1, 2'd2, 1'b0, 1'b1); tick();
    total++;
    if (dsp_tvalid !== 1'b1 || dsp_tlast !== 1'b1) begin
      bad++;
      $display("FAIL dsp_last_beat: got valid=%b last=%b want 1 1", dsp_tvalid, dsp_tlast);
    end
    idle_in();
    repeat (2) tick();
    total++;
    if (obs_dsp - d0 !== 3 || obs_usp - u0 !== 0) begin
      bad++;
      $display("FAIL dsp_pkt_beats: got dsp=%0d usp=%0d want 3 0", obs_dsp - d0, obs_usp - u0);
    end
    total++;
    if (cnt_dsp !== CW'(STATS ? 1 : 0)) begin
      bad++;
      $display("FAIL cnt_dsp_one: got %0d want %0d", cnt_dsp, STATS ? 1 : 0);
    end
    $display("test_dsp_multibeat: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels [3];
    sels[0] = 2'd1;
    sels[1] = 2'd0;
    sels[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b1, sels[i], 1'b0, 1'b1);
      tick();
      total++;
      if (last_tready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_tready%0d: got %b want 1", i, last_tready);
      end
      if (i > 0) begin
        total++;
        if ((sels[i-1] == 2'd1 ? last_usp_v : last_dsp_v) !== 1'b1) begin
          bad++;
          $display("FAIL b2b_out%0d: got dsp_v=%b usp_v=%b want sel %0d output valid",
                   i - 1, last_dsp_v, last_usp_v, sels[i-1]);
        end
      end
    end
    idle_in();
    tick();
    total++;
    if (last_usp_v !== 1'b1 || last_dsp_v !== 1'b0) begin
      bad++;
      $display("FAIL b2b_out2: got dsp_v=%b usp_v=%b want 0 1", last_dsp_v, last_usp_v);
    end
    tick();
    $display("test_back_to_back: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_ur_drop();
    logic [127:0] hdr;
    int d0, u0;
    d0 = obs_dsp;
    u0 = obs_usp;
    ur_ack = 1'b0;
    set_beat(1'b1, 2'd1, 1'b1, 1'b0);
    hdr = s_tdata[127:0];
    tick();
    set_beat(1'b1, 2'd0, 1'b0, 1'b1);
    tick();
    idle_in();
    repeat (2) tick();
    total++;
    if (ur_valid !== 1'b1 || ur_hdr !== hdr) begin
      bad++;
      $display("FAIL ur_capture: got valid=%b hdr=%h want 1 %h", ur_valid, ur_hdr, hdr);
    end
    total++;
    if (obs_dsp - d0 !== 0 || obs_usp - u0 !== 0 || cnt_drop !== CW'(STATS ? 1 : 0)) begin
      bad++;
      $display("FAIL ur_nofwd: got dsp=%0d usp=%0d cnt_drop=%0d want 0 0 %0d",
               obs_dsp - d0, obs_usp - u0, cnt_drop, STATS ? 1 : 0);
    end
    $display("test_ur_drop: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_ur_backpressure();
    logic [127:0] hdr2;
    set_beat(1'b1, 2'd3, 1'b0, 1'b1);
    hdr2 = s_tdata[127:0];
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (last_tready !== 1'b0) begin
        bad++;
        $display("FAIL ur_stall%0d: got tready=%b want 0", i, last_tready);
      end
    end
    ur_ack = 1'b1;
    tick();
    total++;
    if (last_tready !== 1'b1) begin
      bad++;
      $display("FAIL ur_ack_tready: got %b want 1", last_tready);
    end
    ur_ack = 1'b0;
    idle_in();
    tick();
    total++;
    if (ur_valid !== 1'b1 || ur_hdr !== hdr2) begin
      bad++;
      $display("FAIL ur_second: got valid=%b hdr=%h want 1 %h", ur_valid, ur_hdr, hdr2);
    end
    ur_ack = 1'b1;
    tick();
    ur_ack = 1'b0;
    tick();
    total++;
    if (ur_valid !== 1'b0) begin
      bad++;
      $display("FAIL ur_clear: got %b want 0", ur_valid);
    end
    $display("test_ur_backpressure: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    dsp_tready = 1'b1;
    set_beat(1'b1, 2'd0, 1'b0, 1'b0); tick();
    set_beat(1'b1, 2'd3, 1'b1, 1'b0); tick();
    dsp_tready = 1'b0;
    held = dsp_tdata;
    set_beat(1'b1, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (last_tready !== 1'b0 || dsp_tdata !== held) begin
        bad++;
        $display("FAIL stall%0d: got tready=%b data=%h want 0 %h", i, last_tready,
                 dsp_tdata[63:0], held[63:0]);
      end
    end
    dsp_tready = 1'b1;
    send_until_acc("stall_b3");
    set_beat(1'b1, 2'd2, 1'b0, 1'b1);
    send_until_acc("stall_b4");
    idle_in();
    repeat (2) tick();
    $display("test_stall: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_mid();
    int d0, u0;
    dsp_tready = 1'b1;
    usp_tready = 1'b1;
    set_beat(1'b1, 2'd0, 1'b0, 1'b0); tick();
    set_beat(1'b1, 2'd2, 1'b0, 1'b0); tick();
    idle_in();
    #1 user_reset_n = 1'b0;
    #1;
    total++;
    if (dsp_tvalid !== 1'b0 || usp_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got dsp_v=%b usp_v=%b want 0 0", dsp_tvalid, usp_tvalid);
    end
    model_reset();
    @(posedge user_clk);
    @(negedge user_clk);
    user_reset_n = 1'b1;
    d0 = obs_dsp;
    u0 = obs_usp;
    set_beat(1'b1, 2'd1, 1'b0, 1'b1);
    tick();
    idle_in();
    repeat (2) tick();
    total++;
    if (obs_usp - u0 !== 1 || obs_dsp - d0 !== 0) begin
      bad++;
      $display("FAIL post_reset_pkt: got usp=%0d dsp=%0d want 1 0", obs_usp - u0, obs_dsp - d0);
    end
    $display("test_reset_mid: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random();
    int len;
    logic [1:0] sel;
    bit ur;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 4);
      sel = 2'($urandom_range(0, 3));
      ur  = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle_in();
          s_select = 2'($urandom);
          s_ur = 1'($urandom);
          dsp_tready = ($urandom_range(0, 3) != 0);
          usp_tready = ($urandom_range(0, 3) != 0);
          ur_ack = 1'($urandom);
          tick();
        end
        set_beat(1'b1, (b == 0) ? sel : 2'($urandom), (b == 0) ? ur : 1'($urandom), b == len - 1);
        for (int t = 0; t < 50; t++) begin
          dsp_tready = ($urandom_range(0, 3) != 0);
          usp_tready = ($urandom_range(0, 3) != 0);
          ur_ack = 1'($urandom);
          tick();
          if (last_acc) break;
        end
        total++;
        if (!last_acc) begin
          bad++;
          $display("FAIL rand_timeout: got no accept on pkt %0d beat %0d want accept", p, b);
        end
      end
    end
    idle_in();
    dsp_tready = 1'b1;
    usp_tready = 1'b1;
    ur_ack = 1'b1;
    repeat (3) tick();
    total++;
    if ({dsp_tvalid, usp_tvalid, ur_valid} !== 3'b000) begin
      bad++;
      $display("FAIL rand_drain: got %b want 000", {dsp_tvalid, usp_tvalid, ur_valid});
    end
    $display("test_random: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_dsp_multibeat();
    test_back_to_back();
    test_ur_drop();
    test_ur_backpressure();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
